trace_buffer_ctrl: RTL and testbench
====================================

# trace_buffer_ctrl

Circular trace buffer sitting directly downstream of the logic-capture core. Stores every sample packet presented with `write_enable` into an internal RAM, keeps the most recent `2**ADDR_WIDTH` packets, freezes on capture completion, and then serves oldest-first readback to the HUB register interface one packet per request.

## Interface
- `SAMPLE_PACKET_WIDTH`, 32, width of one stored packet.
- `ADDR_WIDTH`, 10, RAM address width; depth `DEPTH = 2**ADDR_WIDTH` (1024).
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `arm` in 1: strobe; clear buffer and start capturing.
- `abort` in 1: strobe; return to IDLE, contents discarded.
- `freeze` in 1: strobe; capture complete, stop writing.
- `samplePacket` in SAMPLE_PACKET_WIDTH: packet from capture core.
- `write_enable` in 1: packet valid this cycle.
- `read_req` in 1: strobe; request next oldest packet.
- `read_data` out SAMPLE_PACKET_WIDTH: returned packet, held until next return.
- `read_valid` out 1: one-cycle pulse, `read_data` valid.
- `read_busy` out 1: a read is in flight.
- `read_empty` out 1: FROZEN with no packets left to read.
- `stored_count` out ADDR_WIDTH+1: packets held, saturates at DEPTH.
- `overflow` out 1: at least one packet overwritten since arm.
- `state` out 2: IDLE=0, CAPTURE=1, FROZEN=2, READOUT=3.

## Operation
- IDLE: writes ignored, read_req ignored. `arm` -> CAPTURE, `wr_ptr=0`, `stored_count=0`, `overflow=0`.
- CAPTURE: each `write_enable` writes `samplePacket` at `wr_ptr`, `wr_ptr` increments mod DEPTH. `stored_count` increments until DEPTH; a write with `stored_count==DEPTH` sets `overflow`. `freeze` -> FROZEN; on entry `rd_ptr = (wr_ptr - stored_count) mod DEPTH`, `remaining = stored_count` (values after that cycle's write).
- FROZEN: `read_req` with `remaining!=0` -> READOUT, RAM read at `rd_ptr`, `rd_ptr++`, `remaining--`. `read_req` with `remaining==0` ignored. `arm` -> CAPTURE (fresh clear).
- READOUT: `read_busy=1`; when data returns, `read_valid` pulses, -> FROZEN. `read_req` during READOUT ignored (no queuing).
- `read_empty = (state==FROZEN) && remaining==0`.
- Priority per cycle: `reset` > `abort` > `arm` > `freeze` > `read_req`. `abort` from any state -> IDLE, `stored_count=0`, `overflow=0`; an in-flight read is dropped (no `read_valid`).
- `write_enable` in the same cycle as `freeze` is stored. `write_enable` with `arm` from CAPTURE/FROZEN is discarded (buffer cleared). `freeze` outside CAPTURE ignored.
- Pointer arithmetic is ADDR_WIDTH bits, natural wrap; counts are ADDR_WIDTH+1 bits.

## Timing
- Reset values: `state=IDLE`, `read_data=0`, `read_valid=0`, `read_busy=0`, `read_empty=0`, `stored_count=0`, `overflow=0`; pointers 0. RAM contents not reset.
- Write: packet in RAM at edge of `write_enable` cycle; `stored_count` updates same edge.
- Read latency: `read_req` sampled at edge N -> `read_valid`/`read_data` at edge N+2 (registered RAM output + output register). Max throughput one packet per 3 cycles.
- `read_data` holds last returned value until next `read_valid`.
- Back-to-back `freeze` then `read_req` on next cycle is legal.

## Structure
- Shared package `trace_buffer_pkg`: state encoding localparams (`TB_IDLE`, `TB_CAPTURE`, `TB_FROZEN`, `TB_READOUT`) so the HUB status register uses identical codes.
- One sub-module `trace_ram`: simple dual-port RAM, one write port, one registered read port, parameterised by `SAMPLE_PACKET_WIDTH`/`ADDR_WIDTH`, no reset, inferable as block RAM.
- Controller FSM, pointers and counters live in `trace_buffer_ctrl`.

## Test plan
- Basic: ADDR_WIDTH=4, arm, write 0x100..0x104 (5 packets), freeze -> `stored_count=5`, `overflow=0`; five read_req -> `read_data` 0x100..0x104, each 2 cycles after req; sixth req -> no `read_valid`, `read_empty=1`.
- Wrap: ADDR_WIDTH=4, write 0x00..0x13 (20), freeze -> `stored_count=16`, `overflow=1`; reads return 0x04..0x13 in order.
- Same-cycle: `write_enable` of 0xAB with `freeze` -> 0xAB is last packet read; `arm` with `write_enable` -> `stored_count=0`.
- Abort mid-read: read_req, `abort` next cycle -> no `read_valid`, `state=0`, `stored_count=0`.
- Ignored requests: read_req during READOUT and in IDLE -> no extra `read_valid`, `remaining` unchanged; `freeze` in IDLE -> stays IDLE.
- Reset mid-capture after 7 writes -> all outputs at reset values next cycle; re-arm starts with `stored_count=0`.

Source files
------------

// File: rtl/trace_buffer_pkg.sv
// Shared encodings for the trace buffer controller and the HUB status register.
package trace_buffer_pkg;

  localparam int unsigned TB_STATE_W = 2;

  localparam logic [TB_STATE_W-1:0] TB_IDLE    = 2'd0;
  localparam logic [TB_STATE_W-1:0] TB_CAPTURE = 2'd1;
  localparam logic [TB_STATE_W-1:0] TB_FROZEN  = 2'd2;
  localparam logic [TB_STATE_W-1:0] TB_READOUT = 2'd3;

endpackage

// File: rtl/trace_buffer_ctrl_if.sv
// Capture-side and HUB-readback signals of the trace buffer.
interface trace_buffer_ctrl_if
  import trace_buffer_pkg::*;
#(
  parameter int unsigned SAMPLE_PACKET_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH          = 10
);

  logic                           arm;
  logic                           abort;
  logic                           freeze;
  logic [SAMPLE_PACKET_WIDTH-1:0] samplePacket;
  logic                           write_enable;
  logic                           read_req;
  logic [SAMPLE_PACKET_WIDTH-1:0] read_data;
  logic                           read_valid;
  logic                           read_busy;
  logic                           read_empty;
  logic [ADDR_WIDTH:0]            stored_count;
  logic                           overflow;
  logic [TB_STATE_W-1:0]          state;

  modport master (
    output arm, abort, freeze, samplePacket, write_enable, read_req,
    input  read_data, read_valid, read_busy, read_empty, stored_count, overflow, state
  );

  modport slave (
    input  arm, abort, freeze, samplePacket, write_enable, read_req,
    output read_data, read_valid, read_busy, read_empty, stored_count, overflow, state
  );

endinterface

// File: rtl/trace_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port, no reset.
module trace_ram #(
  parameter int unsigned SAMPLE_PACKET_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH          = 10
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [SAMPLE_PACKET_WIDTH-1:0] wr_data,
  input  logic                           rd_en,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic [SAMPLE_PACKET_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [SAMPLE_PACKET_WIDTH-1:0] mem [DEPTH];
  logic [SAMPLE_PACKET_WIDTH-1:0] rd_data_q;

  // Block-RAM style write and registered read
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/trace_buffer_ctrl.sv
// Circular trace buffer controller: capture, freeze, oldest-first readback.
module trace_buffer_ctrl
  import trace_buffer_pkg::*;
#(
  parameter int unsigned SAMPLE_PACKET_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH          = 10
) (
  input  logic               clk,
  input  logic               reset,
  trace_buffer_ctrl_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [TB_STATE_W-1:0]          state_q, state_d;
  logic [ADDR_WIDTH-1:0]          wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [CNT_W-1:0]               remaining_q, remaining_d;
  logic                           overflow_q, overflow_d;
  logic                           rd_phase_q, rd_phase_d;
  logic [SAMPLE_PACKET_WIDTH-1:0] read_data_q, read_data_d;
  logic                           read_valid_q, read_valid_d;
  logic                           read_busy_q, read_busy_d;
  logic                           read_empty_q, read_empty_d;

  logic                           ram_we_c;
  logic                           ram_re_c;
  logic [SAMPLE_PACKET_WIDTH-1:0] ram_rdata;

  trace_ram #(
    .SAMPLE_PACKET_WIDTH(SAMPLE_PACKET_WIDTH),
    .ADDR_WIDTH         (ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ram_we_c),
    .wr_addr(wr_ptr_q),
    .wr_data(bus.samplePacket),
    .rd_en  (ram_re_c),
    .rd_addr(rd_ptr_q),
    .rd_data(ram_rdata)
  );

  // Next-state: abort > arm > per-state capture/freeze/readout behaviour
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    remaining_d  = remaining_q;
    overflow_d   = overflow_q;
    rd_phase_d   = rd_phase_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    ram_we_c     = 1'b0;
    ram_re_c     = 1'b0;

    if (bus.abort) begin
      state_d     = TB_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      remaining_d = '0;
      overflow_d  = 1'b0;
      rd_phase_d  = 1'b0;
    end else if (bus.arm) begin
      state_d     = TB_CAPTURE;
      wr_ptr_d    = '0;
      count_d     = '0;
      remaining_d = '0;
      overflow_d  = 1'b0;
      rd_phase_d  = 1'b0;
    end else begin
      case (state_q)
        TB_CAPTURE: begin
          if (bus.write_enable) begin
            ram_we_c = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (count_q == CNT_W'(DEPTH)) overflow_d = 1'b1;
            else                          count_d    = count_q + CNT_W'(1);
          end
          // Oldest packet sits stored_count slots behind the write pointer
          if (bus.freeze) begin
            state_d     = TB_FROZEN;
            rd_ptr_d    = wr_ptr_d - ADDR_WIDTH'(count_d);
            remaining_d = count_d;
          end
        end
        TB_FROZEN: begin
          if (bus.read_req && remaining_q != '0) begin
            state_d     = TB_READOUT;
            remaining_d = remaining_q - CNT_W'(1);
          end
        end
        TB_READOUT: begin
          // Phase 0 reads the RAM, phase 1 registers its output for the HUB
          if (!rd_phase_q) begin
            ram_re_c   = 1'b1;
            rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
            rd_phase_d = 1'b1;
          end else begin
            read_data_d  = ram_rdata;
            read_valid_d = 1'b1;
            rd_phase_d   = 1'b0;
            state_d      = TB_FROZEN;
          end
        end
        default: ;
      endcase
    end

    read_busy_d  = (state_d == TB_READOUT);
    read_empty_d = (state_d == TB_FROZEN) && (remaining_d == '0);
  end

  // State, pointer, counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= TB_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      remaining_q  <= '0;
      overflow_q   <= 1'b0;
      rd_phase_q   <= 1'b0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      read_busy_q  <= 1'b0;
      read_empty_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      remaining_q  <= remaining_d;
      overflow_q   <= overflow_d;
      rd_phase_q   <= rd_phase_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      read_busy_q  <= read_busy_d;
      read_empty_q <= read_empty_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.stored_count = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.read_data    = read_data_q;
  assign bus.read_valid   = read_valid_q;
  assign bus.read_busy    = read_busy_q;
  assign bus.read_empty   = read_empty_q;

endmodule

// File: tb/tb_trace_buffer_ctrl.sv
// Bench for trace_buffer_ctrl: directed scenarios plus random traffic against a queue model.
module tb_trace_buffer_ctrl;
  import trace_buffer_pkg::*;

  localparam int unsigned SPW   = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  trace_buffer_ctrl_if #(.SAMPLE_PACKET_WIDTH(SPW), .ADDR_WIDTH(AW)) bus ();

  trace_buffer_ctrl #(.SAMPLE_PACKET_WIDTH(SPW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: stored packets as a queue, readback as a copy taken at freeze
  logic [SPW-1:0] m_buf[$];
  logic [SPW-1:0] m_rdq[$];
  int             m_state = 0;
  bit             m_ovf   = 1'b0;
  int             m_busy  = 0;
  logic [SPW-1:0] m_pend  = '0;
  logic [SPW-1:0] m_data  = '0;
  bit             m_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_buf.delete();
    m_rdq.delete();
    m_ovf  = 1'b0;
    m_busy = 0;
  endfunction

  function automatic void model_edge(input bit rst, input bit arm, input bit abt, input bit frz,
                                     input bit we, input logic [SPW-1:0] pkt, input bit rreq);
    m_valid = 1'b0;
    if (rst) begin
      model_clear();
      m_state = int'(TB_IDLE);
      m_data  = '0;
    end else if (abt) begin
      model_clear();
      m_state = int'(TB_IDLE);
    end else if (arm) begin
      model_clear();
      m_state = int'(TB_CAPTURE);
    end else if (m_state == int'(TB_CAPTURE)) begin
      if (we) begin
        m_buf.push_back(pkt);
        if (m_buf.size() > DEPTH) begin
          void'(m_buf.pop_front());
          m_ovf = 1'b1;
        end
      end
      if (frz) begin
        m_rdq   = m_buf;
        m_state = int'(TB_FROZEN);
      end
    end else if (m_state == int'(TB_FROZEN)) begin
      if (rreq && m_rdq.size() != 0) begin
        m_pend  = m_rdq.pop_front();
        m_busy  = 2;
        m_state = int'(TB_READOUT);
      end
    end else if (m_state == int'(TB_READOUT)) begin
      m_busy--;
      if (m_busy == 0) begin
        m_valid = 1'b1;
        m_data  = m_pend;
        m_state = int'(TB_FROZEN);
      end
    end
  endfunction

  task automatic compare_all();
    check_eq("state",        64'(bus.state),        64'(m_state));
    check_eq("stored_count", 64'(bus.stored_count), 64'(m_buf.size()));
    check_eq("overflow",     64'(bus.overflow),     64'(m_ovf));
    check_eq("read_valid",   64'(bus.read_valid),   64'(m_valid));
    check_eq("read_data",    64'(bus.read_data),    64'(m_data));
    check_eq("read_busy",    64'(bus.read_busy),    64'(m_state == int'(TB_READOUT)));
    check_eq("read_empty",   64'(bus.read_empty),
             64'(m_state == int'(TB_FROZEN) && m_rdq.size() == 0));
  endtask

  // One clock: drive at negedge, update the model at the edge, sample 1 ns later
  task automatic step(input bit rst, input bit arm, input bit abt, input bit frz,
                      input bit we, input logic [SPW-1:0] pkt, input bit rreq);
    @(negedge clk);
    reset            = rst;
    bus.arm          = arm;
    bus.abort        = abt;
    bus.freeze       = frz;
    bus.write_enable = we;
    bus.samplePacket = pkt;
    bus.read_req     = rreq;
    @(posedge clk);
    model_edge(rst, arm, abt, frz, we, pkt, rreq);
    #1;
    compare_all();
  endtask

  task automatic idle();                     step(0, 0, 0, 0, 0, '0, 0);  endtask
  task automatic do_arm();                   step(0, 1, 0, 0, 0, '0, 0);  endtask
  task automatic do_freeze();                step(0, 0, 0, 1, 0, '0, 0);  endtask
  task automatic do_rd();                    step(0, 0, 0, 0, 0, '0, 1);  endtask
  task automatic do_wr(input logic [SPW-1:0] p); step(0, 0, 0, 0, 1, p, 0); endtask

  initial begin
    reset            = 1'b1;
    bus.arm          = 1'b0;
    bus.abort        = 1'b0;
    bus.freeze       = 1'b0;
    bus.write_enable = 1'b0;
    bus.samplePacket = '0;
    bus.read_req     = 1'b0;

    step(1, 0, 0, 0, 0, '0, 0);
    step(1, 0, 0, 0, 0, '0, 0);
    check_eq("rst_state", 64'(bus.state),        64'(TB_IDLE));
    check_eq("rst_count", 64'(bus.stored_count), 64'h0);
    check_eq("rst_data",  64'(bus.read_data),    64'h0);
    idle();

    // Basic: five packets, oldest first, two cycles after each request
    do_arm();
    for (int i = 0; i < 5; i++) do_wr(SPW'(32'h100 + i));
    do_freeze();
    check_eq("basic_count", 64'(bus.stored_count), 64'd5);
    check_eq("basic_ovf",   64'(bus.overflow),     64'd0);
    for (int i = 0; i < 5; i++) begin
      do_rd();
      idle();
      check_eq("basic_early", 64'(bus.read_valid), 64'd0);
      idle();
      check_eq("basic_valid", 64'(bus.read_valid), 64'd1);
      check_eq("basic_data",  64'(bus.read_data),  64'(32'h100 + i));
    end
    do_rd();
    idle();
    idle();
    check_eq("basic_sixth_valid", 64'(bus.read_valid), 64'd0);
    check_eq("basic_empty",       64'(bus.read_empty), 64'd1);

    // Wrap: 20 writes into 16 slots keeps 0x04..0x13
    do_arm();
    for (int i = 0; i < 20; i++) do_wr(SPW'(i));
    do_freeze();
    check_eq("wrap_count", 64'(bus.stored_count), 64'd16);
    check_eq("wrap_ovf",   64'(bus.overflow),     64'd1);
    for (int i = 0; i < 16; i++) begin
      do_rd();
      idle();
      idle();
      check_eq("wrap_data", 64'(bus.read_data), 64'(4 + i));
    end

    // Write coincident with freeze is kept; write with arm is dropped
    do_arm();
    do_wr(SPW'(32'h11));
    do_wr(SPW'(32'h22));
    step(0, 0, 0, 1, 1, SPW'(32'hAB), 0);
    check_eq("same_count", 64'(bus.stored_count), 64'd3);
    for (int i = 0; i < 3; i++) begin
      do_rd();
      idle();
      idle();
    end
    check_eq("same_last", 64'(bus.read_data), 64'hAB);
    step(0, 1, 0, 0, 1, SPW'(32'h55), 0);
    check_eq("arm_we_count", 64'(bus.stored_count), 64'd0);

    // Abort while a read is in flight
    for (int i = 0; i < 4; i++) do_wr(SPW'(32'h300 + i));
    do_freeze();
    do_rd();
    step(0, 0, 1, 0, 0, '0, 0);
    idle();
    check_eq("abort_valid", 64'(bus.read_valid),   64'd0);
    check_eq("abort_state", 64'(bus.state),        64'(TB_IDLE));
    check_eq("abort_count", 64'(bus.stored_count), 64'd0);

    // Requests in READOUT and IDLE are dropped; freeze in IDLE ignored
    do_rd();
    do_freeze();
    check_eq("idle_freeze", 64'(bus.state), 64'(TB_IDLE));
    do_arm();
    for (int i = 0; i < 3; i++) do_wr(SPW'(32'h400 + i));
    do_freeze();
    do_rd();
    do_rd();
    idle();
    check_eq("ign_first", 64'(bus.read_data), 64'h400);
    idle();
    idle();
    check_eq("ign_no_extra", 64'(bus.read_valid), 64'd0);
    for (int i = 0; i < 2; i++) begin
      do_rd();
      idle();
      idle();
    end
    check_eq("ign_last",  64'(bus.read_data),  64'h402);
    check_eq("ign_empty", 64'(bus.read_empty), 64'd1);

    // Reset in the middle of capture
    do_arm();
    for (int i = 0; i < 7; i++) do_wr(SPW'(32'h500 + i));
    step(1, 0, 0, 0, 0, '0, 0);
    check_eq("rst_mid_state", 64'(bus.state),        64'(TB_IDLE));
    check_eq("rst_mid_count", 64'(bus.stored_count), 64'd0);
    check_eq("rst_mid_data",  64'(bus.read_data),    64'd0);
    do_arm();
    check_eq("rearm_count", 64'(bus.stored_count), 64'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 79) == 0,
           $urandom_range(0, 149) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 1) == 1,
           SPW'($urandom),
           $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
